// File: rtl/csr_pkg.sv
// Shared definitions for the CSR sequencer: CSR addresses, funct3 encodings,
// trap cause codes, sequencer state encoding and the latched request layout.
// Latency: n/a (package). Backpressure: n/a.
// Build option CSR_EXEC_MTVAL_EN adds the TRAP_TVAL state to the encoding.
package csr_pkg;

   // Machine-mode CSR addresses touched by the sequencer
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // SYSTEM-opcode funct3 encodings; bit 2 selects the immediate (zimm) form
   localparam logic [2:0] F3_PRIV   = 3'b000;
   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_RSVD   = 3'b100;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   // Exception cause codes (interrupt bit is always 0 here)
   localparam logic [4:0] CAUSE_ECALL  = 5'd11;
   localparam logic [4:0] CAUSE_EBREAK = 5'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CSR_RD,
      ST_CSR_WR,
      ST_TRAP_EPC,
      ST_TRAP_CAUSE,
`ifdef CSR_EXEC_MTVAL_EN
      ST_TRAP_TVAL,
`endif
      ST_TRAP_VEC,
      ST_MRET_RD,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_CSR,
      OP_ECALL,
      OP_EBREAK,
      OP_MRET
   } op_e;

   // Control fields of an accepted request (data fields are XLEN-sized and
   // kept in the top level)
   typedef struct packed {
      op_e        op;
      logic [2:0] funct3;
      logic [11:0] addr;
      logic [4:0] rs1;
      logic [4:0] rd;
   } req_t;

   // funct3 values 000 and 100 carry no CSR access
   function automatic logic f3_has_access(input logic [2:0] f3);
      return (f3[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/csr_alu.sv
// CSR read-modify-write datapath: computes the new CSR value from old and src.
// Latency: combinational. Backpressure: none.
// Ports: funct3/rs1 (op + rs1 index for suppression), old_val, src -> new_val,
//        wr_suppress (S/C forms with rs1 index 0, or a non-access funct3).
module csr_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [4:0]      rs1,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] new_val,
   output logic            wr_suppress
);

   always_comb begin
      new_val     = old_val;
      wr_suppress = 1'b0;
      case (funct3)
         F3_CSRRW, F3_CSRRWI: new_val = src;
         F3_CSRRS, F3_CSRRSI: begin
            new_val     = old_val | src;
            // rs1 index 0 means "read only": the CSR must not be written
            wr_suppress = (rs1 == 5'd0);
         end
         F3_CSRRC, F3_CSRRCI: begin
            new_val     = old_val & ~src;
            wr_suppress = (rs1 == 5'd0);
         end
         default: wr_suppress = 1'b1;
      endcase
   end

endmodule

// File: rtl/csr_exec.sv
// CSR sequencer: turns one CSR op / ECALL / EBREAK / MRET into CSR-file reads+writes.
// Latency accept->o_done: CSR op 3, trap 4 (5 with MTVAL), MRET 2, no-access funct3 1.
// Backpressure: o_ready only in IDLE; i_valid while busy is ignored (upstream holds).
// Ports: request (i_valid/o_ready, funct3, csr_addr, rs1, rd, rs1_data, pc, system
//        flags), CSR-file port (ren/wr_en/addr/wdata, combinational rdata),
//        completion (o_done, rd write-back, PC redirect), trap-state indicators.
// Build option CSR_EXEC_MTVAL_EN: trap entry also writes MTVAL (pc for ebreak, 0 for ecall).
module csr_exec
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_funct3,
   input  logic [11:0]     i_csr_addr,
   input  logic [4:0]      i_rs1,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_is_ecall,
   input  logic            i_is_ebreak,
   input  logic            i_is_mret,
   output logic            o_csr_ren,
   output logic            o_csr_wr_en,
   output logic [11:0]     o_csr_addr,
   output logic [XLEN-1:0] o_csr_wdata,
   input  logic [XLEN-1:0] i_csr_rdata,
   output logic            o_trap_ecall,
   output logic            o_trap_ebreak,
   output logic            o_done,
   output logic            o_rd_wr_en,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   state_e          state_q, state_d;
   req_t            req_q;
   op_e             op_in;
   logic [XLEN-1:0] rs1_data_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] old_q;
   logic [XLEN-1:0] redir_q;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] new_val;
   logic            wr_suppress;
   logic            rd_skip;
   logic            accept;

   assign accept = i_valid && (state_q == ST_IDLE);

   // System-op priority: ecall > ebreak > mret > CSR op
   always_comb begin
      op_in = OP_CSR;
      if (i_is_ecall)       op_in = OP_ECALL;
      else if (i_is_ebreak) op_in = OP_EBREAK;
      else if (i_is_mret)   op_in = OP_MRET;
   end

   // Immediate forms use the zero-extended rs1 field as the operand
   assign src = req_q.funct3[2] ? XLEN'(req_q.rs1) : rs1_data_q;

   // CSRRW/CSRRWI with rd==0 must not read (avoids read side effects)
   assign rd_skip = (req_q.funct3[1:0] == 2'b01) && (req_q.rd == 5'd0);

   csr_alu #(.XLEN(XLEN)) u_alu (
      .funct3      (req_q.funct3),
      .rs1         (req_q.rs1),
      .old_val     (old_q),
      .src         (src),
      .new_val     (new_val),
      .wr_suppress (wr_suppress)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         rs1_data_q <= '0;
         pc_q       <= '0;
         old_q      <= '0;
         redir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q.op     <= op_in;
            req_q.funct3 <= i_funct3;
            req_q.addr   <= i_csr_addr;
            req_q.rs1    <= i_rs1;
            req_q.rd     <= i_rd;
            rs1_data_q   <= i_rs1_data;
            pc_q         <= i_pc;
            old_q        <= '0;
            redir_q      <= '0;
         end
         // An unread CSR leaves the old value at 0 (it is never written back to rd)
         if (state_q == ST_CSR_RD)
            old_q <= o_csr_ren ? i_csr_rdata : '0;
         // Direct mode only: the MTVEC mode bits are dropped
         if (state_q == ST_TRAP_VEC)
            redir_q <= i_csr_rdata & ALIGN_MASK;
         if (state_q == ST_MRET_RD)
            redir_q <= i_csr_rdata;
      end
   end

   always_comb begin
      state_d       = state_q;
      o_ready       = 1'b0;
      o_csr_ren     = 1'b0;
      o_csr_wr_en   = 1'b0;
      o_csr_addr    = '0;
      o_csr_wdata   = '0;
      o_trap_ecall  = 1'b0;
      o_trap_ebreak = 1'b0;
      o_done        = 1'b0;
      o_rd_wr_en    = 1'b0;
      o_rd_data     = '0;
      o_redirect    = 1'b0;
      o_redirect_pc = '0;

      case (state_q)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               case (op_in)
                  OP_ECALL, OP_EBREAK: state_d = ST_TRAP_EPC;
                  OP_MRET:             state_d = ST_MRET_RD;
                  default:             state_d = f3_has_access(i_funct3) ? ST_CSR_RD : ST_DONE;
               endcase
            end
         end

         ST_CSR_RD: begin
            if (!rd_skip) begin
               o_csr_ren  = 1'b1;
               o_csr_addr = req_q.addr;
            end
            state_d = ST_CSR_WR;
         end

         ST_CSR_WR: begin
            if (!wr_suppress) begin
               o_csr_wr_en = 1'b1;
               o_csr_addr  = req_q.addr;
               o_csr_wdata = new_val;
            end
            state_d = ST_DONE;
         end

         ST_TRAP_EPC: begin
            o_trap_ecall  = (req_q.op == OP_ECALL);
            o_trap_ebreak = (req_q.op == OP_EBREAK);
            o_csr_wr_en   = 1'b1;
            o_csr_addr    = CSR_MEPC;
            o_csr_wdata   = pc_q & ALIGN_MASK;
            state_d       = ST_TRAP_CAUSE;
         end

         ST_TRAP_CAUSE: begin
            o_trap_ecall  = (req_q.op == OP_ECALL);
            o_trap_ebreak = (req_q.op == OP_EBREAK);
            o_csr_wr_en   = 1'b1;
            o_csr_addr    = CSR_MCAUSE;
            o_csr_wdata   = (req_q.op == OP_ECALL) ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_EBREAK);
`ifdef CSR_EXEC_MTVAL_EN
            state_d       = ST_TRAP_TVAL;
`else
            state_d       = ST_TRAP_VEC;
`endif
         end

`ifdef CSR_EXEC_MTVAL_EN
         ST_TRAP_TVAL: begin
            o_trap_ecall  = (req_q.op == OP_ECALL);
            o_trap_ebreak = (req_q.op == OP_EBREAK);
            o_csr_wr_en   = 1'b1;
            o_csr_addr    = CSR_MTVAL;
            o_csr_wdata   = (req_q.op == OP_EBREAK) ? pc_q : '0;
            state_d       = ST_TRAP_VEC;
         end
`endif

         ST_TRAP_VEC: begin
            o_trap_ecall  = (req_q.op == OP_ECALL);
            o_trap_ebreak = (req_q.op == OP_EBREAK);
            o_csr_ren     = 1'b1;
            o_csr_addr    = CSR_MTVEC;
            state_d       = ST_DONE;
         end

         ST_MRET_RD: begin
            o_csr_ren  = 1'b1;
            o_csr_addr = CSR_MEPC;
            state_d    = ST_DONE;
         end

         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
            if (req_q.op == OP_CSR) begin
               o_rd_wr_en = f3_has_access(req_q.funct3) && (req_q.rd != 5'd0);
               o_rd_data  = old_q;
            end else begin
               o_redirect    = 1'b1;
               o_redirect_pc = redir_q;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
